// File: rtl/karatsuba_mul_iter_16_if.sv
// Handshake bundle for the iterative digit-serial multiplier.
// The master side supplies operands and accepts the product. The slave side is the multiplier.
interface karatsuba_mul_iter_16_if #(
  parameter int W = 16
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] C;
  logic           busy;

  modport master (
    output in_valid,
    output A,
    output B,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  C,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  A,
    input  B,
    input  out_ready,
    output in_ready,
    output out_valid,
    output C,
    output busy
  );
endinterface

// File: rtl/karatsuba_mul_iter_16.sv
// Multi-cycle W x W unsigned multiplier.
// Each operand is split into 4-bit digits. One digit pair per clock goes through a
// 4x4 Karatsuba core. The 8-bit partial products are shifted into place and summed
// into a 2W-bit accumulator.
// Latency from the accept edge to out_valid is ND*ND edges and does not depend on the data.
module karatsuba_mul_iter_16 #(
  parameter int W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  karatsuba_mul_iter_16_if.slave  bus
);

  localparam int ND    = W / 4;
  localparam int NPROD = ND * ND;
  localparam int IW    = (ND > 1) ? $clog2(ND) : 1;

  localparam logic [IW-1:0] IDX_ZERO = {IW{1'b0}};
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [IW-1:0] IDX_LAST = IW'(ND - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // 4x4 Karatsuba core: split into 2-bit halves, three 2-3 bit multiplies.
  function automatic logic [7:0] karatsuba_mul_4(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] z2;
    logic [3:0] z0;
    logic [2:0] sa;
    logic [2:0] sb;
    logic [5:0] zm;
    logic [7:0] z1;
    z2 = {2'b00, a[3:2]} * {2'b00, b[3:2]};
    z0 = {2'b00, a[1:0]} * {2'b00, b[1:0]};
    sa = {1'b0, a[3:2]} + {1'b0, a[1:0]};
    sb = {1'b0, b[3:2]} + {1'b0, b[1:0]};
    zm = {3'b000, sa} * {3'b000, sb};
    // The middle term is ah*bl + al*bh and is never negative.
    z1 = {2'b00, zm} - {4'b0000, z2} - {4'b0000, z0};
    return {z2, 4'b0000} + (z1 << 2) + {4'b0000, z0};
  endfunction

  state_t         state_q, state_d;
  logic [W-1:0]   op_a_q, op_a_d;
  logic [W-1:0]   op_b_q, op_b_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [2*W-1:0] c_q, c_d;
  logic [IW-1:0]  i_q, i_d;
  logic [IW-1:0]  j_q, j_d;

  logic [W-1:0]   a_sh_s;
  logic [W-1:0]   b_sh_s;
  logic [3:0]     core_a_s;
  logic [3:0]     core_b_s;
  logic [7:0]     core_c_s;
  logic [IW+2:0]  shamt_s;
  logic [2*W-1:0] pp_s;

  // Select the current digit pair, multiply it, and align the product at 4*(i+j).
  always_comb begin
    a_sh_s   = op_a_q >> {i_q, 2'b00};
    b_sh_s   = op_b_q >> {j_q, 2'b00};
    core_a_s = a_sh_s[3:0];
    core_b_s = b_sh_s[3:0];
    core_c_s = karatsuba_mul_4(core_a_s, core_b_s);
    shamt_s  = {({1'b0, i_q} + {1'b0, j_q}), 2'b00};
    pp_s     = {{(2*W-8){1'b0}}, core_c_s} << shamt_s;
  end

  // Next-state logic: accept in IDLE, accumulate one product per edge in RUN, hold in DONE.
  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    acc_d   = acc_q;
    c_d     = c_q;
    i_d     = i_q;
    j_d     = j_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          op_a_d  = bus.A;
          op_b_d  = bus.B;
          acc_d   = {(2*W){1'b0}};
          i_d     = IDX_ZERO;
          j_d     = IDX_ZERO;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_d = acc_q + pp_s;
        if (j_q == IDX_LAST) begin
          j_d = IDX_ZERO;
          if (i_q == IDX_LAST) begin
            i_d     = IDX_ZERO;
            c_d     = acc_d;
            state_d = ST_DONE;
          end else begin
            i_d = i_q + IDX_ONE;
          end
        end else begin
          j_d = j_q + IDX_ONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_a_q  <= {W{1'b0}};
      op_b_q  <= {W{1'b0}};
      acc_q   <= {(2*W){1'b0}};
      c_q     <= {(2*W){1'b0}};
      i_q     <= IDX_ZERO;
      j_q     <= IDX_ZERO;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      i_q     <= i_d;
      j_q     <= j_d;
    end
  end

  // Handshake outputs are decoded from the registered state.
  // in_ready is held low while reset is asserted.
  assign bus.in_ready  = rst_n & (state_q == ST_IDLE);
  assign bus.busy      = (state_q == ST_RUN);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.C         = c_q;

  // NPROD is the number of RUN edges per operation.
  // It is kept here to document the latency.
  logic [31:0] nprod_unused_s;
  assign nprod_unused_s = 32'(NPROD);

endmodule
